// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side consumer for fifo_asy. Pops the FIFO in full
// bursts of BURST_LEN words, or in a short burst once data has waited
// TIMEOUT cycles. Words leave on a valid/ready stream through a 2-entry skid
// buffer, and m_last flags the final word of each burst.
module fifo_burst_reader #(
   parameter int DATA_BITS = 32,
   parameter int ADDR_BITS = 8,
   parameter int BURST_LEN = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 fifo_en,
   input  logic [DATA_BITS-1:0] fifo_data,
   input  logic                 fifo_empty,
   input  logic [ADDR_BITS-1:0] fifo_data_count,
   output logic                 m_valid,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 busy
);

   // The timer is kept at least 1 bit wide so that TIMEOUT=0 still elaborates.
   // With TIMEOUT=0 it never advances and the short-burst trigger is disabled.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [ADDR_BITS-1:0] BL    = ADDR_BITS'(BURST_LEN);
   localparam logic [TW-1:0]        T_MAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [ADDR_BITS-1:0]  remaining_q, remaining_d;
   logic [1:0]            occ_q, occ_d;
   logic [DATA_BITS-1:0]  b0_data_q, b0_data_d, b1_data_q, b1_data_d;
   logic                  b0_last_q, b0_last_d, b1_last_q, b1_last_d;

   logic full_trig, to_trig, out_pop, new_last;

   assign full_trig = (fifo_data_count >= BL);
   assign to_trig   = (TIMEOUT != 0) && !fifo_empty && (timer_q == T_MAX);

   // The pop is purely combinational and never looks at m_ready. The buffer
   // has two slots, so a pop issued at occupancy 1 always has room to land
   // even if the downstream stalls in the same cycle.
   assign fifo_en  = (state_q == BURST) && !fifo_empty && (occ_q != 2'd2) &&
                     (remaining_q != '0);
   assign new_last = (remaining_q == ADDR_BITS'(1));

   assign m_valid  = (occ_q != 2'd0);
   assign m_data   = b0_data_q;
   assign m_last   = b0_last_q;
   assign out_pop  = m_valid && m_ready;
   assign busy     = (state_q == BURST) || (occ_q != 2'd0);

   // Next state, idle timer and burst word budget.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      remaining_d = remaining_q;
      case (state_q)
         IDLE: begin
            if (full_trig) begin
               state_d     = BURST;
               remaining_d = BL;
               timer_d     = '0;
            end else if (to_trig) begin
               // The count is only a lower bound and can lag the empty flag,
               // so a zero reading still commits to at least one word.
               state_d     = BURST;
               remaining_d = (fifo_data_count == '0) ? ADDR_BITS'(1) : fifo_data_count;
               timer_d     = '0;
            end else if (fifo_empty) begin
               timer_d = '0;
            end else if ((fifo_data_count < BL) && (timer_q < T_MAX)) begin
               timer_d = timer_q + TW'(1);
            end
         end
         BURST: begin
            timer_d = '0;
            if (fifo_en) begin
               remaining_d = remaining_q - ADDR_BITS'(1);
               if (new_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output buffer: slot 0 is the head; pushes land behind whatever remains
   // after this cycle's output pop, so a stalled head is never overwritten.
   always_comb begin
      occ_d     = occ_q;
      b0_data_d = b0_data_q;
      b0_last_d = b0_last_q;
      b1_data_d = b1_data_q;
      b1_last_d = b1_last_q;
      case ({fifo_en, out_pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               b0_data_d = fifo_data;
               b0_last_d = new_last;
            end else begin
               b1_data_d = fifo_data;
               b1_last_d = new_last;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            b0_data_d = b1_data_q;
            b0_last_d = b1_last_q;
            occ_d     = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               b0_data_d = fifo_data;
               b0_last_d = new_last;
            end else begin
               b0_data_d = b1_data_q;
               b0_last_d = b1_last_q;
               b1_data_d = fifo_data;
               b1_last_d = new_last;
            end
         end
         default: ;
      endcase
   end

   // State registers; reset drops any buffered words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         remaining_q <= '0;
         occ_q       <= 2'd0;
         b0_data_q   <= '0;
         b0_last_q   <= 1'b0;
         b1_data_q   <= '0;
         b1_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         remaining_q <= remaining_d;
         occ_q       <= occ_d;
         b0_data_q   <= b0_data_d;
         b0_last_q   <= b0_last_d;
         b1_data_q   <= b1_data_d;
         b1_last_q   <= b1_last_d;
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a small read-side FIFO model feeds the DUT, a
// scoreboard of expected words (with burst-final flags) is checked on every
// accepted beat, and each scenario checks its own pop timing.
module tb_fifo_burst_reader;

   localparam int DB = 32;
   localparam int AB = 8;
   localparam int BL = 16;
   localparam int TO = 64;
   localparam logic [DB-1:0] WBASE = 32'hC0DE_0000;

   typedef struct packed {
      logic [DB-1:0] d;
      logic          l;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_en, fifo_empty, m_valid, m_last, m_ready, busy;
   logic [DB-1:0] fifo_data, m_data;
   logic [AB-1:0] fifo_data_count;

   logic [DB-1:0] mem [0:255];
   int            wp = 0;
   int            rp = 0;
   logic          flush = 1'b0;
   int            occ_m = 0;

   exp_t exp_q[$];
   int   chk = 0;
   int   fails = 0;
   int   beats = 0;
   int   nxt = 0;

   always #5 clk = ~clk;

   fifo_burst_reader #(.DATA_BITS(DB), .ADDR_BITS(AB), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_en(fifo_en), .fifo_data(fifo_data),
      .fifo_empty(fifo_empty), .fifo_data_count(fifo_data_count),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .busy(busy)
   );

   // Read side of the FIFO: data advances at the edge after a pop.
   assign fifo_empty      = (wp == rp);
   assign fifo_data_count = AB'(wp - rp);
   assign fifo_data       = mem[rp[7:0]];

   always @(posedge clk) begin
      if (flush) rp <= wp;
      else if (fifo_en) rp <= rp + 1;
   end

   // Expected output-buffer occupancy: pops in minus beats out.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) occ_m <= 0;
      else occ_m <= occ_m + (fifo_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
   end

   task automatic write_words(input int n, input int grp);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         exp_t e;
         logic [7:0] idx;
         e.d = WBASE + 32'(nxt);
         e.l = (((i + 1) % grp) == 0) || (i == n - 1);
         exp_q.push_back(e);
         idx = 8'(wp + i);
         mem[idx] = e.d;
         nxt++;
      end
      wp = wp + n;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && fifo_empty) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic monitor();
      logic          hold = 1'b0;
      logic [DB-1:0] hd = '0;
      logic          hl = 1'b0;
      exp_t          e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
            continue;
         end
         chk++;
         if (m_valid !== (occ_m != 0)) begin
            fails++;
            $display("FAIL valid_vs_occupancy: m_valid=%b, expected occupancy=%0d", m_valid, occ_m);
         end
         chk++;
         if (fifo_en && occ_m == 2) begin
            fails++;
            $display("FAIL pop_when_full: fifo_en=1 with occupancy=%0d", occ_m);
         end
         if (hold) begin
            chk++;
            if (m_data !== hd || m_last !== hl) begin
               fails++;
               $display("FAIL head_stable: got %h/%b, required %h/%b", m_data, m_last, hd, hl);
            end
         end
         if (m_valid && m_ready) begin
            chk++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL extra_beat: got %h/%b, required no beat", m_data, m_last);
            end else begin
               e = exp_q.pop_front();
               beats++;
               if (m_data !== e.d || m_last !== e.l) begin
                  fails++;
                  $display("FAIL beat: got %h/%b, required %h/%b", m_data, m_last, e.d, e.l);
               end
            end
         end
         hold = m_valid && !m_ready;
         hd   = m_data;
         hl   = m_last;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      chk++;
      if ({fifo_en, m_valid, m_last, busy} !== 4'b0 || m_data !== '0) begin
         fails++;
         $display("FAIL reset_outputs: en/valid/last/busy=%b data=%h, required 0000 / 0",
                  {fifo_en, m_valid, m_last, busy}, m_data);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk++;
      if (busy !== 1'b0 || fifo_en !== 1'b0) begin
         fails++;
         $display("FAIL after_reset_idle: busy=%b fifo_en=%b, required 0 0", busy, fifo_en);
      end
   endtask

   task automatic test_full_burst();
      int first = -1, vfirst = -1, cnt = 0, runs = 0;
      logic prev = 1'b0;
      bit ok;
      write_words(16, BL);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (fifo_en) begin
            if (first < 0) first = i;
            cnt++;
            if (!prev) runs++;
         end
         if (m_valid && vfirst < 0) vfirst = i;
         prev = fifo_en;
      end
      chk++;
      if (first !== 1) begin fails++; $display("FAIL full_first_pop: cycle %0d, required 1", first); end
      chk++;
      if (vfirst !== 2) begin fails++; $display("FAIL full_first_valid: cycle %0d, required 2", vfirst); end
      chk++;
      if (cnt !== 16 || runs !== 1) begin
         fails++;
         $display("FAIL full_contiguous: %0d pops in %0d runs, required 16 in 1", cnt, runs);
      end
      wait_idle(60, ok);
      chk++;
      if (!ok) begin fails++; $display("FAIL full_drain: %0d words left, required 0", exp_q.size()); end
   endtask

   task automatic test_timeout();
      int first = -1, cnt = 0;
      bit ok;
      write_words(5, BL);
      for (int i = 0; i < 90; i++) begin
         @(negedge clk);
         if (fifo_en) begin
            if (first < 0) first = i;
            cnt++;
         end
      end
      chk++;
      if (first !== TO) begin fails++; $display("FAIL timeout_first_pop: cycle %0d, required %0d", first, TO); end
      chk++;
      if (cnt !== 5) begin fails++; $display("FAIL timeout_pops: %0d, required 5", cnt); end
      wait_idle(40, ok);
      chk++;
      if (!ok) begin fails++; $display("FAIL timeout_drain: %0d words left, required 0", exp_q.size()); end
   endtask

   task automatic test_ready_toggle();
      int b0 = beats;
      bit done = 1'b0;
      write_words(16, BL);
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk); #1 m_ready = ~m_ready;
         done = (exp_q.size() == 0) && !busy;
      end
      @(posedge clk); #1 m_ready = 1'b1;
      chk++;
      if (!done || beats - b0 !== 16) begin
         fails++;
         $display("FAIL toggle_beats: %0d beats, required 16", beats - b0);
      end
   endtask

   task automatic test_stall();
      int cnt = 0;
      bit ok;
      @(posedge clk); #1 m_ready = 1'b0;
      write_words(16, BL);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (fifo_en) cnt++;
      end
      chk++;
      if (cnt !== 2) begin fails++; $display("FAIL stall_pops: %0d, required 2", cnt); end
      chk++;
      if (m_valid !== 1'b1 || m_data !== exp_q[0].d) begin
         fails++;
         $display("FAIL stall_head: valid=%b data=%h, required 1 %h", m_valid, m_data, exp_q[0].d);
      end
      @(posedge clk); #1 m_ready = 1'b1;
      wait_idle(60, ok);
      chk++;
      if (!ok) begin fails++; $display("FAIL stall_drain: %0d words left, required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int pops = 0, second = -1, third = -1;
      bit ok;
      write_words(40, BL);
      for (int i = 0; i < 130; i++) begin
         @(negedge clk);
         if (fifo_en) begin
            if (pops == 16) second = i;
            if (pops == 32) third = i;
            pops++;
         end
      end
      chk++;
      if (second !== 18) begin fails++; $display("FAIL b2b_second_burst: cycle %0d, required 18", second); end
      chk++;
      if (third !== 98) begin fails++; $display("FAIL b2b_short_burst: cycle %0d, required 98", third); end
      chk++;
      if (pops !== 40) begin fails++; $display("FAIL b2b_pops: %0d, required 40", pops); end
      wait_idle(40, ok);
      chk++;
      if (!ok) begin fails++; $display("FAIL b2b_drain: %0d words left, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_burst();
      logic [DB-1:0] target;
      int first = -1;
      bit seen = 1'b0, ok;
      target = WBASE + 32'(nxt + 7);
      write_words(16, BL);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = m_valid && (m_data == target);
      end
      chk++;
      if (!seen) begin fails++; $display("FAIL rst_reach_word7: not seen, required %h", target); end
      #2 rst_n = 1'b0;
      #1;
      chk++;
      if ({m_valid, m_last, fifo_en, busy} !== 4'b0) begin
         fails++;
         $display("FAIL rst_async: valid/last/en/busy=%b, required 0000", {m_valid, m_last, fifo_en, busy});
      end
      exp_q.delete();
      flush = 1'b1;
      repeat (2) @(posedge clk);
      #1 flush = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk++;
      if (busy !== 1'b0 || fifo_en !== 1'b0) begin
         fails++;
         $display("FAIL rst_release_idle: busy=%b fifo_en=%b, required 0 0", busy, fifo_en);
      end
      write_words(3, BL);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (fifo_en && first < 0) first = i;
      end
      chk++;
      if (first !== TO) begin fails++; $display("FAIL rst_timer_cleared: pop at %0d, required %0d", first, TO); end
      wait_idle(30, ok);
      chk++;
      if (!ok) begin fails++; $display("FAIL rst_drain: %0d words left, required 0", exp_q.size()); end
   endtask

   initial begin
      m_ready = 1'b1;
      fork
         monitor();
      join_none
      repeat (2) @(posedge clk);
      test_reset();
      test_full_burst();
      test_timeout();
      test_ready_toggle();
      test_stall();
      test_back_to_back();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
      $finish;
   end

endmodule
